// File: rtl/uart_tx_shifter.sv
// uart_tx_shifter: UART TX serializer (start, 5-8 data LSB first, parity, 1/1.5/2 stop); parity logic under `UART_TX_PARITY_EN
module uart_tx_shifter #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BAUDTICK,
  input  logic       TX_VALID,
  input  logic [7:0] TX_DATA,
  output logic       TX_READY,
  input  logic [1:0] WLS,
  input  logic       STB,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  input  logic       BC,
  output logic       SOUT,
  output logic       TX_DONE
);
  localparam int W = $clog2(OVERSAMPLE) + 1;
  localparam logic [W-1:0] FULL_LAST = W'(OVERSAMPLE - 1);
  localparam logic [W-1:0] HALF_LAST = W'(OVERSAMPLE / 2 - 1);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [W-1:0] cnt, cnt_n;
  logic [2:0] bcnt, bcnt_n;
  logic [7:0] shreg, shreg_n;
  logic line, line_n, done_n;
  logic [1:0] wls;
  logic stb;
  logic seg_end;
  logic [7:0] masked;
  logic [2:0] last_bit, stop_last;
`ifdef UART_TX_PARITY_EN
  logic pen, par;
`else
  logic unused_cfg;
  assign unused_cfg = ^{PEN, EPS, SP};
`endif
  assign TX_READY = state == IDLE;
  assign masked = TX_DATA & (8'hFF >> (2'd3 - WLS));
  assign last_bit = {1'b1, wls};
  // Stop is timed in half-bit segments so 1.5 stop bits needs no wider counter.
  assign stop_last = stb ? (wls == 2'b00 ? 3'd2 : 3'd3) : 3'd1;
  assign seg_end = BAUDTICK && cnt == (state == STOP ? HALF_LAST : FULL_LAST);
  // Per-character configuration captured at the handshake.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wls <= 2'b00;
      stb <= 1'b0;
`ifdef UART_TX_PARITY_EN
      pen <= 1'b0;
      par <= 1'b0;
`endif
    end else if (TX_READY && TX_VALID) begin
      wls <= WLS;
      stb <= STB;
`ifdef UART_TX_PARITY_EN
      pen <= PEN;
      par <= SP ? ~EPS : (EPS ? ^masked : ~^masked);
`endif
    end
  end
  // State, counters, shift register and registered outputs; break overrides the line one cycle later.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      bcnt <= '0;
      shreg <= '0;
      line <= 1'b1;
      SOUT <= 1'b1;
      TX_DONE <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bcnt <= bcnt_n;
      shreg <= shreg_n;
      line <= line_n;
      SOUT <= ~BC & line_n;
      TX_DONE <= done_n;
    end
  end
  // Next-state: accept in IDLE, otherwise advance one segment per OVERSAMPLE (or half) ticks.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    bcnt_n = bcnt;
    shreg_n = shreg;
    line_n = line;
    done_n = 1'b0;
    if (state == IDLE) begin
      line_n = 1'b1;
      if (TX_VALID) begin
        state_n = START;
        line_n = 1'b0;
        cnt_n = '0;
        bcnt_n = '0;
        shreg_n = masked;
      end
    end else if (BAUDTICK) begin
      cnt_n = seg_end ? '0 : cnt + 1'b1;
      if (seg_end) begin
        bcnt_n = bcnt + 1'b1;
        case (state)
          START: begin
            state_n = DATA;
            line_n = shreg[0];
            bcnt_n = '0;
          end
          DATA: begin
            shreg_n = shreg >> 1;
            line_n = shreg[1];
            if (bcnt == last_bit) begin
              bcnt_n = '0;
`ifdef UART_TX_PARITY_EN
              state_n = pen ? PARITY : STOP;
              line_n = pen ? par : 1'b1;
`else
              state_n = STOP;
              line_n = 1'b1;
`endif
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            state_n = STOP;
            line_n = 1'b1;
            bcnt_n = '0;
          end
`endif
          default: begin
            if (bcnt == stop_last) begin
              state_n = IDLE;
              done_n = 1'b1;
              bcnt_n = '0;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_shifter.sv
// tb_uart_tx_shifter: scoreboard bench comparing SOUT/TX_READY/TX_DONE with a tick-indexed frame model
module tb_uart_tx_shifter;
  localparam int OS = 16;
  logic clk = 1'b0, rst = 1'b1, baudtick = 1'b0, tx_valid = 1'b0;
  logic stb = 1'b0, pen = 1'b0, eps = 1'b0, sp = 1'b0, bc = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [1:0] wls = 2'b00;
  logic tx_ready, sout, tx_done;
  int checks = 0, failures = 0, tick_per = 1, tcnt = 0;
  bit mon_busy = 1'b0;
  typedef struct {
    logic [11:0] bits;
    int nbits;
    int total;
  } frame_t;
  frame_t q[$];

  uart_tx_shifter #(.OVERSAMPLE(OS)) dut (
    .CLK(clk), .RST(rst), .BAUDTICK(baudtick), .TX_VALID(tx_valid), .TX_DATA(tx_data),
    .TX_READY(tx_ready), .WLS(wls), .STB(stb), .PEN(pen), .EPS(eps), .SP(sp), .BC(bc),
    .SOUT(sout), .TX_DONE(tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Frame as a list of bit values each OS ticks long, followed by the stop time in ticks.
  function automatic frame_t model(input logic [7:0] d, input logic [1:0] w, input logic s,
                                   input logic p, input logic e, input logic k);
    frame_t f;
    int wl, ones;
    wl = 5 + int'(w);
    ones = 0;
    f.bits = '0;
    for (int i = 0; i < wl; i++) begin
      f.bits[1 + i] = d[i];
      ones += int'(d[i]);
    end
    f.nbits = 1 + wl;
`ifdef UART_TX_PARITY_EN
    if (p) begin
      f.bits[f.nbits] = k ? ~e : (e ? (ones % 2 == 1) : (ones % 2 == 0));
      f.nbits++;
    end
`else
    if (p || e || k) ones = ones + 0;
`endif
    f.total = f.nbits * OS + (s ? (w == 2'b00 ? 3 * OS / 2 : 2 * OS) : OS);
    return f;
  endfunction

  task automatic send(input logic [7:0] d, input logic [1:0] w, input logic s, input logic p,
                      input logic e, input logic k, input bit hold);
    int t;
    tx_data = d; wls = w; stb = s; pen = p; eps = e; sp = k; tx_valid = 1'b1;
    q.push_back(model(d, w, s, p, e, k));
    t = 0;
    while (!tx_ready && t < 20000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("send_ready", tx_ready, 1'b1);
    @(posedge clk); #1;
    if (!hold) begin
      tx_valid = 1'b0;
      tx_data = 8'($urandom); wls = 2'($urandom); stb = 1'($urandom);
      pen = 1'($urandom); eps = 1'($urandom); sp = 1'($urandom);
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    tcnt++;
    baudtick = (tick_per == 0) ? 1'($urandom_range(0, 1)) : (tcnt % tick_per == 0);
  end

  // Monitor: pops a frame at each handshake and checks every cycle against it.
  initial begin : mon
    frame_t f;
    int k;
    bit bc_prev, want_done, want_rst;
    k = 0; bc_prev = 1'b0; want_done = 1'b0; want_rst = 1'b1;
    f.bits = '0; f.nbits = 0; f.total = 0;
    forever begin
      @(negedge clk);
      if (want_rst) begin
        chk("rst_sout", sout, 1'b1);
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_done", tx_done, 1'b0);
        want_rst = 1'b0;
      end else if (mon_busy) begin
        chk("frame_sout", sout, bc_prev ? 1'b0 : ((k < f.nbits * OS) ? f.bits[k / OS] : 1'b1));
        chk("frame_ready", tx_ready, 1'b0);
        chk("frame_done", tx_done, 1'b0);
        if (baudtick) k++;
        if (k == f.total) begin
          mon_busy = 1'b0;
          want_done = 1'b1;
        end
      end else begin
        chk("idle_sout", sout, ~bc_prev);
        chk("idle_ready", tx_ready, 1'b1);
        chk("done_pulse", tx_done, want_done);
        want_done = 1'b0;
      end
      if (rst) begin
        mon_busy = 1'b0;
        want_rst = 1'b1;
        want_done = 1'b0;
      end else if (!mon_busy && !want_done && tx_valid && tx_ready) begin
        chk("sb_nonempty", q.size() > 0, 1'b1);
        if (q.size() > 0) begin
          f = q.pop_front();
          k = 0;
          mon_busy = 1'b1;
        end
      end
      bc_prev = bc;
    end
  end

  initial begin
    int t;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    tick_per = 1;
    send(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h83, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send(8'h83, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send(8'h83, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    send(8'h83, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick_per = 3;
    send(8'h3C, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'hC3, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_per = 1;
    send(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(8'h0F, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1 bc = 1'b1;
    repeat (20) @(posedge clk);
    #1 bc = 1'b0;
    send(8'hE7, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (70) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send(8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      tick_per = $urandom_range(0, 3);
      send(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           (i < 39) && ($urandom_range(0, 3) == 0));
    end
    t = 0;
    while ((q.size() != 0 || mon_busy || !tx_ready) && t < 50000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_idle", mon_busy, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", q.size() == 0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
